seg_display_ctrl: RTL and testbench
===================================

Name: seg_display_ctrl

Overview:
Downstream stage of the calculator datapath: consumes the ALU result (unsigned magnitude plus sign and error flags) on a one-cycle load strobe. It converts the result to BCD with a sequential double-dabble engine, then drives the 4-digit multiplexed seven-segment display (seg/an) of the board. The display holds the last committed result until the next accepted load.

Parameters:
REFRESH_CNT, 100000, mclk cycles each digit stays lit; must be >= 2 (bench uses 4).

Ports:
mclk  input  1  system clock
rst  input  1  asynchronous, active-low reset
load  input  1  one-cycle strobe: value/neg/err valid
value  input  16  result magnitude, unsigned
neg  input  1  result is negative
err  input  1  result invalid (e.g. divide by zero)
busy  output  1  conversion in progress; load ignored while high
seg  output  7  active-low segments, {g,f,e,d,c,b,a}
an  output  4  active-low digit enables; an[0] = rightmost digit

Behaviour:
- Reset (rst=0, async): FSM=IDLE, busy=0, an=4'b1111, seg=7'b1111111, refresh counter=0, digit index=0, display regs = {blank,blank,blank,'0'}.
- FSM IDLE: load=1 at an edge captures value, neg, err; go to CONVERT. Overflow flag set at capture: (!neg && value>9999) || (neg && value>999).
- CONVERT: 16 cycles, one shift+add-3 step per cycle on a 16-bit shift reg plus 4x4-bit BCD reg; then UPDATE.
- UPDATE: 1 cycle, commits display regs, returns to IDLE.
- busy=1 exactly 17 cycles, starting the cycle after the accepting edge. New digits are visible on the next scan of each digit after UPDATE.
- load while busy is ignored (no queueing, no restart).
- Display regs change only in UPDATE; never partially updated mid-conversion.
- Digit content at UPDATE, priority order:
  1. err=1 -> digit3..0 = 'E','r','r',blank.
  2. overflow -> "----".
  3. neg=1 -> digit3='-', digits2..0 = hundreds, tens, ones.
  4. Otherwise digits3..0 = thousands..ones.
  5. Leading zeros blanked in cases 3 and 4; ones digit is always shown. Value 0 with neg=1 shows "-  0".
- Scan: refresh counter runs 0..REFRESH_CNT-1; on wrap, the 2-bit digit index increments and wraps 3->0. an = active-low one-hot of the index. seg and an are registered and change on the same edge, so no cycle shows a mismatched pair. Scanning runs continuously from reset release and is independent of the FSM.
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - '-'=0111111, blank=1111111, 'E'=0000110, 'r'=0101111
- Reset mid-conversion: abort immediately; state, busy and display return to reset values.
- Target size: ~200 lines RTL.

Test Plan:
- Hold rst=0 -> an=1111, seg=1111111. Release with REFRESH_CNT=4 -> an cycles 1110,1101,1011,0111 every 4 clocks; seg=1000000 when an=1110, 1111111 otherwise.
- load value=15, neg=0, err=0 -> busy high for exactly 17 cycles, then low. Digit0=0010010, digit1=1111001, digits2/3=1111111.
- load value=3, neg=1 -> digit3=0111111, digits2/1 blank, digit0=0110000. Then load value=999, neg=1 -> "-999", digit3=0111111, digits2..0=0010000.
- load value=10000, neg=0 -> all digits 0111111. Load value=1000, neg=1 -> "----". Load value=9999, neg=0 -> all digits 0010000.
- load err=1 with value=42 -> digit3=0000110, digit2=digit1=0101111, digit0=1111111.
- load value=15, then load value=77 pulsed 5 cycles later (busy=1) -> second load ignored, display shows "15". Then load value=88 and drop rst to 0 at cycle 8 of CONVERT -> outputs reset immediately; after release, display shows "0".

Source files
------------

// File: rtl/seg_display_ctrl.sv
// ALU result to 4-digit multiplexed seven-segment display.
// Sequential double-dabble BCD conversion, then a free-running digit scan.
module seg_display_ctrl #(
    parameter int REFRESH_CNT = 100000
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        neg,
    input  logic        err,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int RW = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CNT - 1);

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_DASH  = 7'b0111111;
    localparam logic [6:0] S_E     = 7'b0000110;
    localparam logic [6:0] S_R     = 7'b0101111;
    localparam logic [6:0] S_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = S_BLANK;
        endcase
        return s;
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       bin_q, bin_d;
    logic [15:0]       bcd_q, bcd_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic [3:0][6:0]   disp_q, disp_d;
    logic [3:0][6:0]   disp_new;
    logic [15:0]       bcd_adj;

    logic [RW-1:0]     ref_q, ref_d;
    logic [1:0]        idx_q, idx_d;
    logic [6:0]        seg_q;
    logic [3:0]        an_q;

    // Add-3 on any BCD nibble >= 5 before each shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        logic [3:0] th, hu, te, on;
        th = bcd_q[15:12];
        hu = bcd_q[11:8];
        te = bcd_q[7:4];
        on = bcd_q[3:0];
        disp_new = {S_BLANK, S_BLANK, S_BLANK, seg_of(on)};
        if (err_q) begin
            disp_new = {S_E, S_R, S_R, S_BLANK};
        end else if (ovf_q) begin
            disp_new = {S_DASH, S_DASH, S_DASH, S_DASH};
        end else if (neg_q) begin
            disp_new[3] = S_DASH;
            disp_new[2] = (hu != 4'd0) ? seg_of(hu) : S_BLANK;
            disp_new[1] = (hu != 4'd0 || te != 4'd0) ? seg_of(te) : S_BLANK;
        end else begin
            disp_new[3] = (th != 4'd0) ? seg_of(th) : S_BLANK;
            disp_new[2] = (th != 4'd0 || hu != 4'd0) ? seg_of(hu) : S_BLANK;
            disp_new[1] = (th != 4'd0 || hu != 4'd0 || te != 4'd0)
                        ? seg_of(te) : S_BLANK;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    neg_d   = neg;
                    err_d   = err;
                    ovf_d   = (!neg && value > 16'd9999)
                            || (neg && value > 16'd999);
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                disp_d  = disp_new;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= {S_BLANK, S_BLANK, S_BLANK, S_ZERO};
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        ref_d = (ref_q == REF_MAX) ? '0 : ref_q + RW'(1);
        idx_d = (ref_q == REF_MAX) ? idx_q + 2'd1 : idx_q;
    end

    // seg and an registered together so each pair is always consistent
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            ref_q <= '0;
            idx_q <= '0;
            seg_q <= S_BLANK;
            an_q  <= 4'b1111;
        end else begin
            ref_q <= ref_d;
            idx_q <= idx_d;
            seg_q <= disp_q[idx_q];
            an_q  <= ~(4'b0001 << idx_q);
        end
    end

    assign busy = (state_q != IDLE);
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: arithmetic display model checked every
// cycle, plus directed loads with hand-computed segment patterns.
module tb_seg_display_ctrl;

    localparam int RC = 4;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SR = 7'b0101111;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D9 = 7'b0010000;

    typedef logic [3:0][6:0] disp_t;

    logic        mclk = 1'b0;
    logic        rst;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic        neg = 1'b0;
    logic        err = 1'b0;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;

    int passed = 0;
    int total  = 0;

    always #5 mclk = ~mclk;

    seg_display_ctrl #(.REFRESH_CNT(RC)) dut (
        .mclk  (mclk),
        .rst   (rst),
        .load  (load),
        .value (value),
        .neg   (neg),
        .err   (err),
        .busy  (busy),
        .seg   (seg),
        .an    (an)
    );

    task automatic chk(input string name, input int unsigned act,
                       input int unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BL;
        endcase
    endfunction

    function automatic disp_t build(input int v, input bit n, input bit e);
        disp_t r;
        if (e) begin
            r = {SE, SR, SR, BL};
        end else if ((!n && v > 9999) || (n && v > 999)) begin
            r = {DS, DS, DS, DS};
        end else if (n) begin
            r[3] = DS;
            r[2] = (v >= 100) ? code((v / 100) % 10) : BL;
            r[1] = (v >= 10) ? code((v / 10) % 10) : BL;
            r[0] = code(v % 10);
        end else begin
            r[3] = (v >= 1000) ? code((v / 1000) % 10) : BL;
            r[2] = (v >= 100) ? code((v / 100) % 10) : BL;
            r[1] = (v >= 10) ? code((v / 10) % 10) : BL;
            r[0] = code(v % 10);
        end
        return r;
    endfunction

    // Model: time-based scan position, 17-edge busy countdown
    disp_t      m_disp;
    disp_t      m_pend;
    int         m_n;
    int         m_rem;
    logic [6:0] m_seg;
    logic [3:0] m_an;
    logic       m_busy;

    always @(posedge mclk or negedge rst) begin
        int k;
        if (!rst) begin
            m_disp = {BL, BL, BL, D0};
            m_n    = 0;
            m_rem  = 0;
            m_seg  = BL;
            m_an   = 4'b1111;
            m_busy = 1'b0;
        end else begin
            k     = (m_n / RC) % 4;
            m_seg = m_disp[k];
            m_an  = ~(4'b0001 << k);
            m_n++;
            if (m_rem == 0) begin
                if (load) begin
                    m_pend = build(int'(value), neg, err);
                    m_rem  = 17;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_disp = m_pend;
            end
            m_busy = (m_rem > 0);
        end
    end

    always @(negedge mclk) begin
        if (!rst) begin
            chk("rst_an", an, 4'b1111);
            chk("rst_seg", seg, BL);
            chk("rst_busy", busy, 0);
        end else begin
            chk("busy", busy, m_busy);
            chk("an", an, m_an);
            chk("seg", seg, m_seg);
        end
    end

    task automatic tick;
        @(posedge mclk);
        #2;
    endtask

    task automatic do_load(input int v, input bit n, input bit e);
        value = 16'(v);
        neg   = n;
        err   = e;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic load_wait(input int v, input bit n, input bit e);
        int len;
        bit done;
        len  = 0;
        done = 0;
        do_load(v, n, e);
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) begin
                len++;
                tick();
            end else begin
                done = 1;
            end
        end
        chk($sformatf("busy_len v=%0d", v), len, 17);
    endtask

    task automatic check_digit(input int i, input logic [6:0] exp);
        bit seen;
        seen = 0;
        chk($sformatf("model_digit%0d", i), m_disp[i], exp);
        for (int j = 0; j < 20 && !seen; j++) begin
            tick();
            if (an == ~(4'b0001 << i)) begin
                seen = 1;
                chk($sformatf("digit%0d", i), seg, exp);
            end
        end
        if (!seen) chk($sformatf("digit%0d_timeout", i), 0, 1);
    endtask

    task automatic check_all(input logic [6:0] d3, input logic [6:0] d2,
                             input logic [6:0] d1, input logic [6:0] d0);
        check_digit(3, d3);
        check_digit(2, d2);
        check_digit(1, d1);
        check_digit(0, d0);
    endtask

    initial begin
        logic [3:0] anl [4];
        bit done;
        anl[0] = 4'b1110;
        anl[1] = 4'b1101;
        anl[2] = 4'b1011;
        anl[3] = 4'b0111;

        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) tick();
        chk("hold_an", an, 4'b1111);
        chk("hold_seg", seg, BL);

        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("scan_an%0d", k), an, anl[(k - 1) / 4]);
            chk($sformatf("scan_seg%0d", k), seg,
                ((k - 1) / 4 == 0) ? D0 : BL);
        end

        load_wait(15, 0, 0);
        check_all(BL, BL, D1, D5);
        load_wait(3, 1, 0);
        check_all(DS, BL, BL, D3);
        load_wait(999, 1, 0);
        check_all(DS, D9, D9, D9);
        load_wait(10000, 0, 0);
        check_all(DS, DS, DS, DS);
        load_wait(1000, 1, 0);
        check_all(DS, DS, DS, DS);
        load_wait(9999, 0, 0);
        check_all(D9, D9, D9, D9);
        load_wait(42, 0, 1);
        check_all(SE, SR, SR, BL);
        load_wait(0, 1, 0);
        check_all(DS, BL, BL, D0);
        load_wait(1205, 0, 0);
        check_all(D1, D2, D0, D5);

        do_load(15, 0, 0);
        repeat (4) tick();
        chk("busy_at_2nd_load", busy, 1);
        do_load(77, 0, 0);
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) tick();
            else done = 1;
        end
        chk("ignore_idle", done, 1);
        check_all(BL, BL, D1, D5);

        do_load(88, 0, 0);
        repeat (7) tick();
        chk("mid_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_an", an, 4'b1111);
        chk("mid_rst_seg", seg, BL);
        repeat (2) tick();
        rst = 1'b1;
        check_all(BL, BL, BL, D0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d",
                 passed, total);
        $fatal(1);
    end

endmodule
